lif_update_scheduler: RTL

Time-multiplexes one shared LIF membrane-update datapath across `NUM_NEURONS` neurons. The block owns the per-neuron membrane and refractory state and sweeps every neuron once per timestep `tick`. For each neuron it issues an update request to the external datapath, then applies threshold, reset and refractory rules to the result. It sits between the stimulus front end and the STDP synapse logic, which consumes the per-timestep spike vector it publishes.

---
 rtl/lif_update_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lif_update_scheduler.sv
// Sweeps NUM_NEURONS LIF neurons through one shared membrane-update datapath per tick,
// owning membrane/refractory state and publishing the per-timestep spike vector.
module lif_update_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_BITS    = 2,
  parameter int WIDTH       = 8,
  parameter int V_REST      = -64,
  parameter int V_THRESH    = 32,
  parameter int REFRACT     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [NUM_NEURONS*WIDTH-1:0] i_stim,
  output logic                         dp_valid,
  input  logic                         dp_ready,
  output logic [IDX_BITS-1:0]          dp_idx,
  output logic [WIDTH-1:0]             dp_v,
  output logic [WIDTH-1:0]             dp_i,
  input  logic                         res_valid,
  input  logic [WIDTH-1:0]             res_v,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_NEURONS-1:0]       spikes,
  output logic                         overrun
);
  localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
  localparam logic signed [WIDTH-1:0] VREST = WIDTH'(V_REST);
  localparam logic signed [WIDTH-1:0] VTH   = WIDTH'(V_THRESH);
  localparam logic [RW-1:0]           RINIT = RW'(REFRACT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
  state_t state;

  logic [NUM_NEURONS-1:0][WIDTH-1:0] vmem;
  logic [NUM_NEURONS-1:0][WIDTH-1:0] stim_snap;
  logic [NUM_NEURONS-1:0][RW-1:0]    refr;
  logic [NUM_NEURONS-1:0]            spike_next;
  logic [IDX_BITS-1:0]               idx;
  logic [WIDTH-1:0]                  res_q;

  logic [IDX_BITS-1:0]    idx_nxt;
  logic                   last;
  logic                   fire;
  logic [NUM_NEURONS-1:0] idx_hot;

  always_comb begin
    idx_nxt = idx + IDX_BITS'(1);
    last    = (idx == IDX_BITS'(NUM_NEURONS - 1));
    fire    = ($signed(res_q) >= VTH);
    idx_hot = NUM_NEURONS'(1) << idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      vmem       <= {NUM_NEURONS{VREST}};
      refr       <= '0;
      stim_snap  <= '0;
      spike_next <= '0;
      idx        <= '0;
      res_q      <= '0;
      spikes     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dp_valid   <= 1'b0;
      dp_idx     <= '0;
      dp_v       <= '0;
      dp_i       <= '0;
      overrun    <= 1'b0;
    end else begin
      done <= 1'b0;
      // A tick outside IDLE is lost, never queued.
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          stim_snap  <= i_stim;
          idx        <= '0;
          spike_next <= '0;
          busy       <= 1'b1;
          dp_valid   <= (refr[0] == '0);
          dp_idx     <= '0;
          dp_v       <= vmem[0];
          dp_i       <= i_stim[WIDTH-1:0];
          state      <= ISSUE;
        end
        ISSUE: begin
          if (refr[idx] != '0) begin
            refr[idx] <= refr[idx] - RW'(1);
            vmem[idx] <= VREST;
            if (last) begin
              spikes <= spike_next;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              idx      <= idx_nxt;
              dp_valid <= (refr[idx_nxt] == '0);
              dp_idx   <= idx_nxt;
              dp_v     <= vmem[idx_nxt];
              dp_i     <= stim_snap[idx_nxt];
            end
          end else if (dp_ready) begin
            dp_valid <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: if (res_valid) begin
          res_q <= res_v;
          state <= WRITE;
        end
        WRITE: begin
          if (fire) begin
            vmem[idx]       <= VREST;
            spike_next[idx] <= 1'b1;
            refr[idx]       <= RINIT;
          end else begin
            vmem[idx] <= res_q;
          end
          if (last) begin
            // spike_next is updated on this same edge, so fold the final neuron in here.
            spikes <= spike_next | (fire ? idx_hot : '0);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx      <= idx_nxt;
            dp_valid <= (refr[idx_nxt] == '0);
            dp_idx   <= idx_nxt;
            dp_v     <= vmem[idx_nxt];
            dp_i     <= stim_snap[idx_nxt];
            state    <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
